// File: rtl/shift_pipe_if.sv
// shift_pipe_if: operand-issue and writeback-side handshake bundle for shift_pipe.
// The master side presents operands and consumes results; the slave side is the shifter.
interface shift_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    localparam int SW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [SW-1:0]    in_amt;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic             out_illegal;

    modport master (
        output in_valid, in_a, in_amt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_zero, out_illegal
    );

    modport slave (
        input  in_valid, in_a, in_amt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_zero, out_illegal
    );
endinterface

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter with one registered stage per shift-amount bit.
// Stage k shifts by 2^(k-1) when amt[k-1] is set. A valid/ready chain gives full
// backpressure and lets empty stages (bubbles) fill while the output is stalled.
module shift_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        flush,
    shift_pipe_if.slave bus
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    // Stage registers, indexed 1..SW; stage SW drives the output side.
    logic             valid_q [1:SW];
    logic [WIDTH-1:0] data_q  [1:SW];
    logic [SW-1:0]    amt_q   [1:SW];
    logic [2:0]       op_q    [1:SW];
    logic [TAG_W-1:0] tag_q   [1:SW];
    logic             sign_q  [1:SW];
    logic             zero_q;
    logic             illegal_q;

    // adv[k] = stage k may load this cycle; adv[SW+1] is the consumer's ready.
    logic [SW+1:1]    adv;

    // What each stage would load: the previous stage's fields (or the inputs for stage 1).
    logic             src_valid [1:SW];
    logic [WIDTH-1:0] src_data  [1:SW];
    logic [SW-1:0]    src_amt   [1:SW];
    logic [2:0]       src_op    [1:SW];
    logic [TAG_W-1:0] src_tag   [1:SW];
    logic             src_sign  [1:SW];
    logic [WIDTH-1:0] nxt_data  [1:SW];

    // The last stage's amt/op/sign are held for completeness but nothing downstream reads them.
    logic             unused_last_stage;

    // One fixed-distance step of the selected operation; illegal ops pass data through.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       op,
        input logic             sign,
        input int               s
    );
        logic [2*WIDTH-1:0] ext;
        logic [WIDTH-1:0]   r;
        ext = {{WIDTH{sign}}, d} >> s;
        case (op)
            OP_SLL:  r = d << s;
            OP_SRL:  r = d >> s;
            OP_SRA:  r = ext[WIDTH-1:0];
            OP_ROL:  r = (d << s) | (d >> (WIDTH - s));
            OP_ROR:  r = (d >> s) | (d << (WIDTH - s));
            default: r = d;
        endcase
        return r;
    endfunction

    // Advance chain: a stage moves when it is empty or the stage after it moves.
    always_comb begin
        adv[SW+1] = bus.out_ready;
        for (int k = SW; k >= 1; k--) begin
            adv[k] = !valid_q[k] || adv[k+1];
        end
    end

    // Gather each stage's source fields and apply that stage's shift step.
    always_comb begin
        src_valid[1] = bus.in_valid && adv[1];
        src_data[1]  = bus.in_a;
        src_amt[1]   = bus.in_amt;
        src_op[1]    = bus.in_op;
        src_tag[1]   = bus.in_tag;
        src_sign[1]  = bus.in_a[WIDTH-1];
        for (int k = 2; k <= SW; k++) begin
            src_valid[k] = valid_q[k-1];
            src_data[k]  = data_q[k-1];
            src_amt[k]   = amt_q[k-1];
            src_op[k]    = op_q[k-1];
            src_tag[k]   = tag_q[k-1];
            src_sign[k]  = sign_q[k-1];
        end
        for (int k = 1; k <= SW; k++) begin
            nxt_data[k] = src_amt[k][k-1]
                        ? shift_step(src_data[k], src_op[k], src_sign[k], 1 << (k - 1))
                        : src_data[k];
        end
    end

    // Stage registers: load on advance, hold on stall, flush drops every valid bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 1; k <= SW; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
                amt_q[k]   <= '0;
                op_q[k]    <= '0;
                tag_q[k]   <= '0;
                sign_q[k]  <= 1'b0;
            end
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            for (int k = 1; k <= SW; k++) begin
                if (flush) begin
                    valid_q[k] <= 1'b0;
                end else if (adv[k]) begin
                    valid_q[k] <= src_valid[k];
                    data_q[k]  <= nxt_data[k];
                    amt_q[k]   <= src_amt[k];
                    op_q[k]    <= src_op[k];
                    tag_q[k]   <= src_tag[k];
                    sign_q[k]  <= src_sign[k];
                end
            end
            if (!flush && adv[SW]) begin
                zero_q    <= (nxt_data[SW] == '0);
                illegal_q <= (src_op[SW] > OP_ROR);
            end
        end
    end

    assign bus.in_ready    = adv[1];
    assign bus.out_valid   = valid_q[SW];
    assign bus.out_result  = data_q[SW];
    assign bus.out_tag     = tag_q[SW];
    assign bus.out_zero    = zero_q;
    assign bus.out_illegal = illegal_q;

    assign unused_last_stage = ^{amt_q[SW], op_q[SW], sign_q[SW]};
endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: table-driven directed vectors, a randomized backpressured stream
// checked against a bit-at-a-time reference model, plus flush and reset sequences.
module tb_shift_pipe;
    logic clock = 1'b0;
    logic reset_n;
    logic flush;

    always #5 clock = ~clock;

    shift_pipe_if #(.WIDTH(32), .TAG_W(4)) b32 ();
    shift_pipe_if #(.WIDTH(8),  .TAG_W(4)) b8 ();

    shift_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (b32.slave)
    );

    shift_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (b8.slave)
    );

    localparam logic [2:0] SLL = 3'd0;
    localparam logic [2:0] SRL = 3'd1;
    localparam logic [2:0] SRA = 3'd2;
    localparam logic [2:0] ROL = 3'd3;
    localparam logic [2:0] ROR = 3'd4;

    typedef struct {
        bit          w8;
        logic [2:0]  op;
        logic [63:0] a;
        int          amt;
        logic [3:0]  tag;
        logic [63:0] res;
        logic        zero;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic        zero;
        logic        ill;
    } exp_t;

    int   checks = 0;
    int   miscompares = 0;
    vec_t vecs [11];

    // Reference: apply the operation one bit position at a time on a w-bit value.
    function automatic logic [63:0] refShift(input logic [63:0] a, input int amt,
                                             input logic [2:0] op, input int w);
        logic [63:0] mask;
        logic [63:0] msb;
        logic [63:0] r;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        msb  = 64'd1 << (w - 1);
        r    = a & mask;
        for (int i = 0; i < amt; i++) begin
            case (op)
                SLL:     r = (r << 1) & mask;
                SRL:     r = r >> 1;
                SRA:     r = (r >> 1) | (r & msb);
                ROL:     r = ((r << 1) | (r >> (w - 1))) & mask;
                ROR:     r = (r >> 1) | ((r & 64'd1) << (w - 1));
                default: r = r;
            endcase
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit w8, input logic vld, input logic [63:0] a, input int amt,
                         input logic [2:0] op, input logic [3:0] tag);
        if (w8) begin
            b8.in_valid = vld;
            b8.in_a     = a[7:0];
            b8.in_amt   = amt[2:0];
            b8.in_op    = op;
            b8.in_tag   = tag;
        end else begin
            b32.in_valid = vld;
            b32.in_a     = a[31:0];
            b32.in_amt   = amt[4:0];
            b32.in_op    = op;
            b32.in_tag   = tag;
        end
    endtask

    task automatic idleAll();
        drive(1'b0, 1'b0, 64'd0, 0, SLL, 4'd0);
        drive(1'b1, 1'b0, 64'd0, 0, SLL, 4'd0);
    endtask

    // Present one operand into an empty pipe, then time and check its result.
    task automatic applyStimulus(input vec_t v, input string name);
        int   edges;
        bit   seen;
        logic [63:0] res;
        logic [3:0]  tag;
        logic        zero;
        logic        ill;
        drive(v.w8, 1'b1, v.a, v.amt, v.op, v.tag);
        @(posedge clock); #1;
        drive(v.w8, 1'b0, 64'd0, 0, SLL, 4'd0);
        edges = 1;
        seen  = 1'b0;
        while (!seen && edges < 20) begin
            if (v.w8 ? b8.out_valid : b32.out_valid) begin
                seen = 1'b1;
            end else begin
                @(posedge clock); #1;
                edges++;
            end
        end
        res  = v.w8 ? {56'd0, b8.out_result} : {32'd0, b32.out_result};
        tag  = v.w8 ? b8.out_tag : b32.out_tag;
        zero = v.w8 ? b8.out_zero : b32.out_zero;
        ill  = v.w8 ? b8.out_illegal : b32.out_illegal;
        checkOutput({name, "_latency"}, 64'(edges), v.w8 ? 64'd3 : 64'd5);
        checkOutput({name, "_result"}, res, v.res);
        checkOutput({name, "_tag"}, 64'(tag), 64'(v.tag));
        checkOutput({name, "_zero"}, 64'(zero), 64'(v.zero));
        checkOutput({name, "_illegal"}, 64'(ill), 64'(v.ill));
        @(posedge clock); #1;
    endtask

    // Two operands on consecutive edges must emerge on consecutive cycles.
    task automatic runBackToBack();
        drive(1'b0, 1'b1, 64'h0000_0001, 31, SLL, 4'd1);
        @(posedge clock); #1;
        drive(1'b0, 1'b1, 64'h8000_0000, 4, SRA, 4'd2);
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 64'd0, 0, SLL, 4'd0);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("b2b_first_valid", 64'(b32.out_valid), 64'd1);
        checkOutput("b2b_first_result", 64'(b32.out_result), 64'h8000_0000);
        @(posedge clock); #1;
        checkOutput("b2b_second_valid", 64'(b32.out_valid), 64'd1);
        checkOutput("b2b_second_result", 64'(b32.out_result), 64'hF800_0000);
        @(posedge clock); #1;
    endtask

    // Twelve random operands with a seven-cycle output stall in the middle.
    task automatic runStream();
        exp_t expQ [$];
        int   inFlight = 0;
        int   received = 0;
        bit   fellSeen = 1'b0;
        bit   fullChecked = 1'b0;
        int   extra = 0;
        fork
            begin
                logic [31:0] a;
                int          amt;
                logic [2:0]  op;
                logic [63:0] r;
                exp_t        e;
                bit          hs;
                int          guard;
                for (int i = 0; i < 12; i++) begin
                    a   = $urandom;
                    amt = $urandom_range(0, 31);
                    op  = 3'($urandom_range(0, 7));
                    r   = refShift({32'd0, a}, amt, op, 32);
                    e.res  = r[31:0];
                    e.tag  = 4'(i);
                    e.zero = (r == 64'd0);
                    e.ill  = (op > ROR);
                    expQ.push_back(e);
                    drive(1'b0, 1'b1, {32'd0, a}, amt, op, 4'(i));
                    guard = 0;
                    do begin
                        @(negedge clock);
                        hs = b32.in_ready;
                        @(posedge clock); #1;
                        guard++;
                    end while (!hs && guard < 40);
                end
                drive(1'b0, 1'b0, 64'd0, 0, SLL, 4'd0);
            end
            begin
                repeat (3) @(posedge clock);
                #1 b32.out_ready = 1'b0;
                repeat (7) @(posedge clock);
                #1 b32.out_ready = 1'b1;
            end
            begin
                exp_t e;
                for (int c = 0; c < 300 && received < 12; c++) begin
                    @(negedge clock);
                    if (!b32.in_ready && !fellSeen) begin
                        fellSeen = 1'b1;
                        checkOutput("stream_held_at_stall", 64'(inFlight), 64'd5);
                    end
                    if (b32.out_ready && inFlight == 5 && !fullChecked) begin
                        fullChecked = 1'b1;
                        checkOutput("stream_full_pass_ready", 64'(b32.in_ready), 64'd1);
                    end
                    if (b32.in_valid && b32.in_ready) inFlight++;
                    if (b32.out_valid && b32.out_ready) begin
                        inFlight--;
                        received++;
                        if (expQ.size() == 0) begin
                            checkOutput("stream_unexpected_out", 64'd1, 64'd0);
                        end else begin
                            e = expQ.pop_front();
                            checkOutput("stream_tag", 64'(b32.out_tag), 64'(e.tag));
                            checkOutput("stream_result", 64'(b32.out_result), 64'(e.res));
                            checkOutput("stream_zero", 64'(b32.out_zero), 64'(e.zero));
                            checkOutput("stream_illegal", 64'(b32.out_illegal), 64'(e.ill));
                        end
                    end
                end
            end
        join
        checkOutput("stream_received", 64'(received), 64'd12);
        checkOutput("stream_ready_fell", 64'(fellSeen), 64'd1);
        checkOutput("stream_full_pass_seen", 64'(fullChecked), 64'd1);
        repeat (8) begin
            @(negedge clock);
            if (b32.out_valid) extra++;
        end
        checkOutput("stream_no_duplicate", 64'(extra), 64'd0);
        @(posedge clock); #1;
    endtask

    // Flush with three ops in flight and a fourth presented on the flush edge.
    task automatic runFlush();
        int seen = 0;
        drive(1'b0, 1'b1, 64'h0000_00F0, 2, SLL, 4'd1);
        @(posedge clock); #1;
        drive(1'b0, 1'b1, 64'h0000_0F00, 3, SRL, 4'd2);
        @(posedge clock); #1;
        drive(1'b0, 1'b1, 64'hF000_000F, 5, ROL, 4'd3);
        @(posedge clock); #1;
        flush = 1'b1;
        drive(1'b0, 1'b1, 64'h1111_1111, 1, SLL, 4'd9);
        @(posedge clock); #1;
        flush = 1'b0;
        drive(1'b0, 1'b0, 64'd0, 0, SLL, 4'd0);
        repeat (10) begin
            @(negedge clock);
            if (b32.out_valid) seen++;
        end
        checkOutput("flush_no_output", 64'(seen), 64'd0);
        @(posedge clock); #1;
        applyStimulus(vecs[2], "flush_next_op");
    endtask

    // Async reset mid-stream with a result parked at the output.
    task automatic runReset();
        int g = 0;
        int seen = 0;
        b32.out_ready = 1'b0;
        drive(1'b0, 1'b1, 64'h1234_5678, 8, 3'b111, 4'hA);
        @(posedge clock); #1;
        drive(1'b0, 1'b1, 64'h0000_00F1, 4, ROR, 4'hB);
        @(posedge clock); #1;
        drive(1'b0, 1'b1, 64'h0000_0003, 1, SLL, 4'hC);
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 64'd0, 0, SLL, 4'd0);
        while (!b32.out_valid && g < 20) begin
            @(posedge clock); #1;
            g++;
        end
        checkOutput("rst_pre_valid", 64'(b32.out_valid), 64'd1);
        checkOutput("rst_pre_result", 64'(b32.out_result), 64'h1234_5678);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_async_valid", 64'(b32.out_valid), 64'd0);
        checkOutput("rst_async_result", 64'(b32.out_result), 64'd0);
        checkOutput("rst_async_tag", 64'(b32.out_tag), 64'd0);
        checkOutput("rst_async_zero", 64'(b32.out_zero), 64'd0);
        checkOutput("rst_async_illegal", 64'(b32.out_illegal), 64'd0);
        b32.out_ready = 1'b1;
        #1;
        checkOutput("rst_in_ready", 64'(b32.in_ready), 64'd1);
        drive(1'b0, 1'b1, 64'h0000_00FF, 1, SLL, 4'hD);
        @(posedge clock);
        @(posedge clock); #1;
        @(negedge clock);
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 64'd0, 0, SLL, 4'd0);
        repeat (8) begin
            @(negedge clock);
            if (b32.out_valid) seen++;
        end
        checkOutput("rst_no_stale", 64'(seen), 64'd0);
        @(posedge clock); #1;
        applyStimulus(vecs[3], "rst_next_op");
    endtask

    // Watchdog so a stuck handshake still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b0, SLL,    64'h0000_0001, 31, 4'd1,  64'h8000_0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, SRA,    64'h8000_0000, 4,  4'd2,  64'hF800_0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, ROR,    64'h0000_00F1, 4,  4'd3,  64'h1000_000F, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, ROL,    64'h8000_0001, 1,  4'd4,  64'h0000_0003, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, SRL,    64'hFFFF_FFFF, 31, 4'd5,  64'h0000_0001, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 3'b111, 64'h1234_5678, 8,  4'd6,  64'h1234_5678, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, SLL,    64'h0000_0100, 24, 4'd7,  64'h0000_0000, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, SRA,    64'h8000_0000, 0,  4'd8,  64'h8000_0000, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, SRA,    64'h0000_0090, 3,  4'd9,  64'h0000_00F2, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, ROL,    64'h0000_0081, 7,  4'd10, 64'h0000_00C0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 3'b101, 64'h0000_0000, 3,  4'd11, 64'h0000_0000, 1'b1, 1'b1};

        reset_n = 1'b0;
        flush   = 1'b0;
        idleAll();
        b32.out_ready = 1'b1;
        b8.out_ready  = 1'b1;
        #2;
        checkOutput("reset_out_valid", 64'(b32.out_valid), 64'd0);
        checkOutput("reset_out_result", 64'(b32.out_result), 64'd0);
        checkOutput("reset_out_tag", 64'(b32.out_tag), 64'd0);
        checkOutput("reset_out_zero", 64'(b32.out_zero), 64'd0);
        checkOutput("reset_out_illegal", 64'(b32.out_illegal), 64'd0);
        checkOutput("reset_in_ready", 64'(b32.in_ready), 64'd1);
        checkOutput("reset_w8_out_valid", 64'(b8.out_valid), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        runBackToBack();
        runStream();
        runFlush();
        runReset();

        $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
        $finish;
    end
endmodule
